// File: rtl/ring_token_arbiter.sv
// ring_token_arbiter
//   Shares the core's single ring stop among NREQ local ring masters. The
//   circulating Token slot is captured and granted round-robin to one
//   requesting master. That master's slots are muxed onto the ring for its
//   whole burst. When the burst ends, the Token is re-emitted on the next
//   empty (Null) upstream slot. All other traffic passes through unchanged.
//
// Ports
//   clock, reset              core clock, async active-high reset
//   whichCore                 this core's ring source number
//   RingIn/SlotTypeIn/SourceIn  upstream slot
//   wantsToken[NREQ]          level-held token request per master
//   driveRing[NREQ]           master claims the current slot
//   mRingOut/mSlotTypeOut     per-master slot payload/type, packed by index
//   acquireToken[NREQ]        one-hot grant pulse (combinational)
//   RingOut/SlotTypeOut/SourceOut  downstream slot
//   grantIdx                  current or last granted master
//   errBurst                  sticky: burst watchdog fired
//   errDupToken               sticky: a Token arrived while a burst was open

// Per-master lane: grant pulse and AND-gated slot contribution for the
// OR-reduced output mux.
module ring_token_arbiter_lane (
  input  logic        grant,
  input  logic        regrant,
  input  logic        muxHere,
  input  logic [31:0] data,
  input  logic [3:0]  slotType,
  output logic        acquire,
  output logic [31:0] dataQ,
  output logic [3:0]  typeQ
);
  assign acquire = grant | regrant;
  assign dataQ   = muxHere ? data : '0;
  assign typeQ   = muxHere ? slotType : '0;
endmodule

module ring_token_arbiter #(
  parameter int NREQ      = 3,
  parameter int MAX_BURST = 64,
  parameter int TW        = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        whichCore,
  input  logic [31:0]       RingIn,
  input  logic [3:0]        SlotTypeIn,
  input  logic [3:0]        SourceIn,
  input  logic [NREQ-1:0]   wantsToken,
  input  logic [NREQ-1:0]   driveRing,
  input  logic [32*NREQ-1:0] mRingOut,
  input  logic [4*NREQ-1:0] mSlotTypeOut,
  output logic [NREQ-1:0]   acquireToken,
  output logic [31:0]       RingOut,
  output logic [3:0]        SlotTypeOut,
  output logic [3:0]        SourceOut,
  output logic [1:0]        grantIdx,
  output logic              errBurst,
  output logic              errDupToken
);

  localparam logic [3:0] SLOT_TOKEN = 4'd1;
  localparam logic [3:0] SLOT_NULL  = 4'd7;

  typedef enum logic [1:0] {IDLE, BUSY, REISSUE} stateT;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  slotType;
    logic [3:0]  source;
  } slotT;

  stateT          state;
  logic [1:0]     rrPtr;
  logic [TW-1:0]  watchdog;

  logic [NREQ-1:0][31:0] mData;
  logic [NREQ-1:0][3:0]  mType;
  assign mData = mRingOut;
  assign mType = mSlotTypeOut;

  // First requester at or after ptr, wrapping modulo NREQ. Scanning from
  // the far end lets the nearest requester overwrite the result.
  function automatic logic [1:0] pickNext(input logic [NREQ-1:0] req,
                                          input logic [1:0] ptr);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = 2'((int'(ptr) + k) % NREQ);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  logic       tokenIn, nullIn;
  logic [1:0] sel, nextPtr, muxSel;
  logic       curDrive, curWant;
  logic       wdFire, grantNow, busyDrive, regrant, emitToken, muxOn;

  always_comb begin
    tokenIn  = (SlotTypeIn == SLOT_TOKEN);
    nullIn   = (SlotTypeIn == SLOT_NULL);
    sel      = pickNext(wantsToken, rrPtr);
    nextPtr  = (int'(sel) == NREQ - 1) ? 2'd0 : sel + 2'd1;
    curDrive = driveRing[grantIdx];
    curWant  = wantsToken[grantIdx];
    // Watchdog counts slots already driven. Once it reaches the limit, the
    // burst is cut off and the master's drive in that cycle is not honoured.
    wdFire    = (state == BUSY) && (watchdog == TW'(MAX_BURST));
    // Reset gates every combinational path, so nothing is granted or muxed
    // while reset is held.
    grantNow  = !reset && (state == IDLE) && tokenIn && (|wantsToken);
    // A stray Token always wins the slot over the master's drive.
    busyDrive = !reset && (state == BUSY) && !wdFire && !tokenIn && curDrive;
    // The grantee re-raising its want mid-burst is granted immediately.
    // The Token is still held here, so there is nothing to wait for.
    regrant   = !reset && (state == BUSY) && !wdFire && !curDrive && curWant;
    emitToken = !reset && (state == REISSUE) && nullIn;
    muxOn     = grantNow | busyDrive;
    muxSel    = grantNow ? sel : grantIdx;
  end

  logic [NREQ-1:0]       laneAcq;
  logic [NREQ-1:0][31:0] laneData;
  logic [NREQ-1:0][3:0]  laneType;

  for (genvar i = 0; i < NREQ; i++) begin : gLane
    ring_token_arbiter_lane uLane (
      .grant    (grantNow && (sel == 2'(i))),
      .regrant  (regrant && (grantIdx == 2'(i))),
      .muxHere  (muxOn && (muxSel == 2'(i))),
      .data     (mData[i]),
      .slotType (mType[i]),
      .acquire  (laneAcq[i]),
      .dataQ    (laneData[i]),
      .typeQ    (laneType[i])
    );
  end

  assign acquireToken = laneAcq;

  logic [31:0] laneDataOr;
  logic [3:0]  laneTypeOr;
  slotT        outSlot;

  always_comb begin
    laneDataOr = '0;
    laneTypeOr = '0;
    for (int i = 0; i < NREQ; i++) begin
      laneDataOr |= laneData[i];
      laneTypeOr |= laneType[i];
    end
    outSlot = '{data: RingIn, slotType: SlotTypeIn, source: SourceIn};
    if (muxOn)
      outSlot = '{data: laneDataOr, slotType: laneTypeOr, source: whichCore};
    else if (emitToken)
      outSlot = '{data: 32'd0, slotType: SLOT_TOKEN, source: whichCore};
  end

  assign RingOut     = outSlot.data;
  assign SlotTypeOut = outSlot.slotType;
  assign SourceOut   = outSlot.source;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rrPtr       <= '0;
      grantIdx    <= '0;
      watchdog    <= '0;
      errBurst    <= 1'b0;
      errDupToken <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grantNow) begin
            grantIdx <= sel;
            rrPtr    <= nextPtr;
            watchdog <= TW'(1);
            // A grantee that does not take its grant slot has released the
            // ring; the Token must be regenerated.
            state    <= driveRing[sel] ? BUSY : REISSUE;
          end
        end
        BUSY: begin
          if (tokenIn) errDupToken <= 1'b1;
          if (wdFire) begin
            errBurst <= 1'b1;
            state    <= REISSUE;
          end else if (curDrive) begin
            if (!tokenIn) watchdog <= watchdog + TW'(1);
          end else if (!curWant) begin
            state <= REISSUE;
          end
        end
        REISSUE: begin
          if (nullIn) begin
            state    <= IDLE;
            watchdog <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_token_arbiter.sv
module tb_ring_token_arbiter;
  localparam int NREQ = 3;
  localparam int MAX_BURST = 64;
  localparam int TW = 7;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  whichCore = 4'd5;
  logic [31:0] ringIn = '0;
  logic [3:0]  slotTypeIn = 4'd7;
  logic [3:0]  sourceIn = '0;
  logic [2:0]  wants = '0;
  logic [2:0]  drv = '0;
  logic [95:0] mData = '0;
  logic [11:0] mType = '0;

  logic [2:0]  acq;
  logic [31:0] ringOut;
  logic [3:0]  slotTypeOut, sourceOut;
  logic [1:0]  grantIdx;
  logic        errBurst, errDup;

  int checks = 0;
  int errors = 0;

  ring_token_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST), .TW(TW)) dut (
    .clock(clock), .reset(reset), .whichCore(whichCore),
    .RingIn(ringIn), .SlotTypeIn(slotTypeIn), .SourceIn(sourceIn),
    .wantsToken(wants), .driveRing(drv),
    .mRingOut(mData), .mSlotTypeOut(mType),
    .acquireToken(acq), .RingOut(ringOut), .SlotTypeOut(slotTypeOut),
    .SourceOut(sourceOut), .grantIdx(grantIdx),
    .errBurst(errBurst), .errDupToken(errDup)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: who owns the ring, how many slots it has driven,
  // whether a Token is owed to the ring, and the round-robin preference.
  int owner = -1;
  int driven = 0;
  int nextPref = 0;
  int lastGrant = 0;
  bit owed = 0;
  bit mB = 0;
  bit mD = 0;

  always @(negedge clock) begin : compare
    logic [2:0]  eAcq;
    logic [31:0] eData;
    logic [3:0]  eType, eSrc;
    logic [1:0]  eGrant;
    bit eB, eD, tok, nul;
    int s, g;
    eAcq = '0; eData = ringIn; eType = slotTypeIn; eSrc = sourceIn;
    eGrant = 2'(lastGrant); eB = mB; eD = mD;
    tok = (slotTypeIn == 4'd1);
    nul = (slotTypeIn == 4'd7);
    if (reset) begin
      eGrant = '0; eB = 0; eD = 0;
    end else if (owner < 0 && !owed) begin
      if (tok && wants != 0) begin
        s = -1;
        for (int k = 0; k < NREQ; k++)
          if (s < 0 && wants[(nextPref + k) % NREQ]) s = (nextPref + k) % NREQ;
        eAcq = 3'(1 << s);
        eData = mData[32*s +: 32]; eType = mType[4*s +: 4]; eSrc = whichCore;
        lastGrant = s; nextPref = (s + 1) % NREQ; driven = 1;
        if (drv[s]) owner = s; else owed = 1;
      end
    end else if (owner >= 0) begin
      g = owner;
      if (tok) mD = 1;
      if (driven == MAX_BURST) begin
        mB = 1; owner = -1; owed = 1;
      end else begin
        if (!drv[g] && wants[g]) eAcq = 3'(1 << g);
        if (drv[g] && !tok) begin
          eData = mData[32*g +: 32]; eType = mType[4*g +: 4]; eSrc = whichCore;
          driven++;
        end else if (!drv[g] && !wants[g]) begin
          owner = -1; owed = 1;
        end
      end
    end else if (nul) begin
      eData = '0; eType = 4'd1; eSrc = whichCore; owed = 0; driven = 0;
    end
    chk("acquireToken", 32'(acq), 32'(eAcq));
    chk("RingOut", ringOut, eData);
    chk("SlotTypeOut", 32'(slotTypeOut), 32'(eType));
    chk("SourceOut", 32'(sourceOut), 32'(eSrc));
    chk("grantIdx", 32'(grantIdx), 32'(eGrant));
    chk("errBurst", 32'(errBurst), 32'(eB));
    chk("errDupToken", 32'(errDup), 32'(eD));
    if (reset) begin
      owner = -1; driven = 0; nextPref = 0; lastGrant = 0; owed = 0; mB = 0; mD = 0;
    end
  end

  task automatic cyc(input logic [2:0] w, input logic [2:0] d,
                     input logic [3:0] st, input logic [31:0] rin);
    @(posedge clock);
    #1;
    wants = w; drv = d; slotTypeIn = st; ringIn = rin; sourceIn = 4'd9;
  endtask

  initial begin
    int r;
    mData = {32'h1234_5678, 32'h2222_0000, 32'hA000_0000};
    mType = {4'd2, 4'd3, 4'd3};

    // Token with requesters while reset is held: nothing granted.
    cyc(3'b101, 3'b001, 4'd1, 32'h1111_0000);
    #3;
    chk("rst_acq", 32'(acq), 32'd0);
    chk("rst_ringout", ringOut, 32'h1111_0000);
    chk("rst_errs", 32'({errBurst, errDup}), 32'd0);
    cyc(3'b101, 3'b000, 4'd7, 32'h0);
    reset = 1'b0;

    // Masters 0 and 2 want; master 0 wins and drives 9 slots.
    cyc(3'b101, 3'b001, 4'd1, 32'h1111_0000);
    #3;
    chk("grant0_acq", 32'(acq), 32'b001);
    chk("grant0_data", ringOut, 32'hA000_0000);
    chk("grant0_src", 32'(sourceOut), 32'd5);
    for (int n = 1; n <= 8; n++) begin
      cyc(3'b101, 3'b001, 4'd7, 32'h0);
      mData[31:0] = 32'hA000_0000 + 32'(n);
    end
    #3;
    chk("burst0_last", ringOut, 32'hA000_0008);
    cyc(3'b100, 3'b000, 4'd7, 32'h0);
    #3;
    chk("burst0_end_pass", 32'(slotTypeOut), 32'd7);
    cyc(3'b100, 3'b000, 4'd7, 32'h0);
    #3;
    chk("reissue_type", 32'(slotTypeOut), 32'd1);
    chk("reissue_src", 32'(sourceOut), 32'd5);
    chk("reissue_data", ringOut, 32'd0);
    chk("reissue_gidx", 32'(grantIdx), 32'd0);
    chk("reissue_noacq", 32'(acq), 32'd0);

    // Second Token, rrPtr=1: master 2 wins.
    cyc(3'b101, 3'b100, 4'd1, 32'h3333_0000);
    #3;
    chk("grant2_acq", 32'(acq), 32'b100);
    chk("grant2_data", ringOut, 32'h1234_5678);
    cyc(3'b000, 3'b000, 4'd7, 32'h0);
    #3;
    chk("grant2_gidx", 32'(grantIdx), 32'd2);
    cyc(3'b000, 3'b000, 4'd7, 32'h0);

    // Token with no requester passes through.
    cyc(3'b000, 3'b000, 4'd1, 32'hDEAD_0000);
    #3;
    chk("nowant_data", ringOut, 32'hDEAD_0000);
    chk("nowant_type", 32'(slotTypeOut), 32'd1);
    chk("nowant_src", 32'(sourceOut), 32'd9);
    chk("nowant_acq", 32'(acq), 32'd0);
    cyc(3'b000, 3'b000, 4'd7, 32'h0);
    #3;
    chk("nowant_idle", 32'(slotTypeOut), 32'd7);

    // Master 1 holds drive for 70 slots: watchdog cuts it off.
    cyc(3'b010, 3'b010, 4'd1, 32'h0);
    #3;
    chk("wd_acq", 32'(acq), 32'b010);
    for (int n = 1; n <= 69; n++) begin
      cyc(3'b010, 3'b010, 4'd7, 32'h0);
      mData[63:32] = 32'h2222_0000 + 32'(n);
      #3;
      if (n == 63) chk("wd_slot64", ringOut, 32'h2222_003F);
      if (n == 64) begin
        chk("wd_cut_type", 32'(slotTypeOut), 32'd7);
        chk("wd_cut_err", 32'(errBurst), 32'd0);
      end
      if (n == 65) begin
        chk("wd_token", 32'(slotTypeOut), 32'd1);
        chk("wd_err", 32'(errBurst), 32'd1);
      end
      if (n == 66) chk("wd_nomux", ringOut, 32'd0);
    end
    cyc(3'b000, 3'b000, 4'd7, 32'h0);

    // Duplicate Token during a burst.
    cyc(3'b001, 3'b001, 4'd1, 32'h0);
    #3;
    chk("dup_acq", 32'(acq), 32'b001);
    cyc(3'b001, 3'b001, 4'd1, 32'hBEEF_0001);
    #3;
    chk("dup_pass", ringOut, 32'hBEEF_0001);
    chk("dup_type", 32'(slotTypeOut), 32'd1);
    cyc(3'b001, 3'b001, 4'd7, 32'h0);
    #3;
    chk("dup_err", 32'(errDup), 32'd1);
    cyc(3'b000, 3'b000, 4'd7, 32'h0);
    cyc(3'b000, 3'b000, 4'd7, 32'h0);
    #3;
    chk("dup_sticky", 32'(errDup), 32'd1);

    // Randomised traffic checked by the model.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clock);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 5) == 0) wants[i] = ~wants[i];
        if ($urandom_range(0, 7) == 0) drv[i] = ~drv[i];
      end
      r = int'($urandom_range(0, 99));
      slotTypeIn = (r < 8) ? 4'd1 : (r < 50) ? 4'd7 : (r < 70) ? 4'd2 : (r < 85) ? 4'd3 : 4'd4;
      ringIn = $urandom;
      sourceIn = 4'($urandom);
      mData = {$urandom, $urandom, $urandom};
      mType = 12'($urandom);
      if (n % 100 == 0) whichCore = 4'($urandom);
      reset = ($urandom_range(0, 199) == 0);
    end

    // Reset in the middle of a burst, at slot 4.
    reset = 1'b0;
    repeat (3) cyc(3'b000, 3'b000, 4'd7, 32'h0);
    cyc(3'b001, 3'b001, 4'd1, 32'h0);
    cyc(3'b001, 3'b001, 4'd7, 32'h0);
    cyc(3'b001, 3'b001, 4'd7, 32'h0);
    cyc(3'b001, 3'b001, 4'd7, 32'h4444_0000);
    reset = 1'b1;
    #3;
    chk("midrst_acq", 32'(acq), 32'd0);
    chk("midrst_pass", ringOut, 32'h4444_0000);
    chk("midrst_type", 32'(slotTypeOut), 32'd7);
    chk("midrst_errs", 32'({errBurst, errDup}), 32'd0);
    chk("midrst_gidx", 32'(grantIdx), 32'd0);
    cyc(3'b001, 3'b001, 4'd7, 32'h0);
    reset = 1'b0;
    cyc(3'b001, 3'b001, 4'd7, 32'h5555_0000);
    #3;
    chk("postrst_idle", ringOut, 32'h5555_0000);
    repeat (2) @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
